// File: rtl/switch_debounce_sync_pkg.sv
// Shared defaults and the parameter legality check for the switch conditioning block.
package switch_debounce_sync_pkg;

   localparam int DEF_N_CH            = 4;
   localparam int DEF_CNT_W           = 16;
   localparam int DEF_DEBOUNCE_CYCLES = 50000;

   // The counter stops at D-1, so D must be at least 1 and must fit in CNT_W bits.
   function automatic bit debounceRangeOk(input int cycles, input int cntW);
      return (cycles >= 1) && (longint'(cycles) <= ((longint'(1) << cntW) - 1));
   endfunction

endpackage

// File: rtl/switch_debounce_sync_debounce_channel.sv
// One switch channel: two-flop synchroniser, stability counter and registered edge strobes.
import switch_debounce_sync_pkg::*;

module debounce_channel #(
   parameter int CNT_W           = DEF_CNT_W,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_in,
   output logic sw_out,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_out;
   logic             r_rise;
   logic             r_fall;

   // Any cycle where the synchronised level agrees with the output discards counting progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_cnt   <= '0;
         r_out   <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync1 <= sw_in;
         r_sync2 <= r_sync1;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         if (r_sync2 == r_out) begin
            r_cnt <= '0;
         end else if (r_cnt == TERM) begin
            r_out  <= r_sync2;
            r_cnt  <= '0;
            r_rise <= r_sync2;
            r_fall <= ~r_sync2;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign sw_out = r_out;
   assign rise   = r_rise;
   assign fall   = r_fall;

endmodule

// File: rtl/switch_debounce_sync.sv
// Top of the switch conditioning stage: N_CH independent debounce channels plus a change flag.
import switch_debounce_sync_pkg::*;

module switch_debounce_sync #(
   parameter int N_CH            = DEF_N_CH,
   parameter int CNT_W           = DEF_CNT_W,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] sw_in,
   output logic [N_CH-1:0] sw_out,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic            changed
);

   if (!debounceRangeOk(DEBOUNCE_CYCLES, CNT_W)) begin : g_badParam
      $error("DEBOUNCE_CYCLES must be within 1..2**CNT_W-1");
   end

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
      debounce_channel #(
         .CNT_W           (CNT_W),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .clk    (clk),
         .rst_n  (rst_n),
         .sw_in  (sw_in[ch]),
         .sw_out (sw_out[ch]),
         .rise   (rise[ch]),
         .fall   (fall[ch])
      );
   end

   assign changed = |(rise | fall);

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Directed bench for switch_debounce_sync with a run-length reference model checked every cycle.
module tb_switch_debounce_sync;

   localparam int N_CH  = 4;
   localparam int CNT_W = 3;
   localparam int D     = 4;

   logic            clk;
   logic            rst_n;
   logic [N_CH-1:0] sw_in;
   logic [N_CH-1:0] sw_out;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
   logic            changed;

   int compared = 0;
   int mismatched = 0;

   switch_debounce_sync #(
      .N_CH            (N_CH),
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_in   (sw_in),
      .sw_out  (sw_out),
      .rise    (rise),
      .fall    (fall),
      .changed (changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a level is accepted once the 2-cycle-delayed input has differed for D edges in a row.
   logic [N_CH-1:0] hist[$];
   logic [N_CH-1:0] seen;
   logic [N_CH-1:0] expOut;
   logic [N_CH-1:0] expRise;
   logic [N_CH-1:0] expFall;
   int              runLen[N_CH];
   bit              modelValid = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         hist = {};
         hist.push_back('0);
         hist.push_back('0);
         expOut  = '0;
         expRise = '0;
         expFall = '0;
         for (int c = 0; c < N_CH; c++) runLen[c] = 0;
         modelValid = 1'b1;
      end else if (modelValid) begin
         seen    = hist.pop_front();
         expRise = '0;
         expFall = '0;
         for (int c = 0; c < N_CH; c++) begin
            if (seen[c] != expOut[c]) begin
               runLen[c]++;
               if (runLen[c] == D) begin
                  expOut[c] = seen[c];
                  runLen[c] = 0;
                  if (seen[c]) expRise[c] = 1'b1;
                  else         expFall[c] = 1'b1;
               end
            end else begin
               runLen[c] = 0;
            end
         end
         hist.push_back(sw_in);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Outputs are registered, so the falling edge sees a settled value for every cycle.
   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("model_sw_out",  32'(sw_out),  32'(expOut));
         checkOutput("model_rise",    32'(rise),    32'(expRise));
         checkOutput("model_fall",    32'(fall),    32'(expFall));
         checkOutput("model_changed", 32'(changed), 32'(|(expRise | expFall)));
      end
   end

   task automatic applyStimulus(input logic rstVal, input logic [N_CH-1:0] swVal, input int cycles);
      rst_n = rstVal;
      sw_in = swVal;
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      sw_in = 4'hF;

      // Reset held with all switches high
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("rst_sw_out",  32'(sw_out),  32'h0);
         checkOutput("rst_rise",    32'(rise),    32'h0);
         checkOutput("rst_fall",    32'(fall),    32'h0);
         checkOutput("rst_changed", 32'(changed), 32'h0);
      end
      applyStimulus(1'b1, 4'h0, 4);
      checkOutput("idle_sw_out", 32'(sw_out), 32'h0);

      // Clean press on ch0: edge 5 after change is the sixth posedge
      applyStimulus(1'b1, 4'h1, 5);
      checkOutput("press_before", 32'(sw_out[0]), 32'h0);
      applyStimulus(1'b1, 4'h1, 1);
      checkOutput("press_sw_out",  32'(sw_out[0]), 32'h1);
      checkOutput("press_rise",    32'(rise[0]),    32'h1);
      checkOutput("press_changed", 32'(changed),    32'h1);
      applyStimulus(1'b1, 4'h1, 1);
      checkOutput("press_rise_drop", 32'(rise[0]), 32'h0);
      checkOutput("press_fall",      32'(fall),    32'h0);

      // Bounce on ch1, then held high
      applyStimulus(1'b1, 4'h3, 2);
      applyStimulus(1'b1, 4'h1, 2);
      applyStimulus(1'b1, 4'h3, 2);
      applyStimulus(1'b1, 4'h1, 2);
      checkOutput("bounce_no_accept", 32'(sw_out[1]), 32'h0);
      applyStimulus(1'b1, 4'h3, 5);
      checkOutput("bounce_before", 32'(sw_out[1]), 32'h0);
      applyStimulus(1'b1, 4'h3, 1);
      checkOutput("bounce_sw_out", 32'(sw_out[1]), 32'h1);
      checkOutput("bounce_rise",   32'(rise[1]),   32'h1);

      // Short glitch on ch2, then a real press that must take the full latency
      applyStimulus(1'b1, 4'h7, 3);
      applyStimulus(1'b1, 4'h3, 10);
      checkOutput("glitch_sw_out", 32'(sw_out[2]), 32'h0);
      applyStimulus(1'b1, 4'h7, 5);
      checkOutput("glitch_clear_before", 32'(sw_out[2]), 32'h0);
      applyStimulus(1'b1, 4'h7, 1);
      checkOutput("glitch_clear_rise", 32'(rise[2]), 32'h1);
      applyStimulus(1'b1, 4'h7, 2);

      // Simultaneous ch0 release and ch3 press
      applyStimulus(1'b1, 4'hE, 6);
      checkOutput("simul_fall0",   32'(fall[0]),  32'h1);
      checkOutput("simul_rise3",   32'(rise[3]),  32'h1);
      checkOutput("simul_changed", 32'(changed),  32'h1);
      checkOutput("simul_sw_out",  32'(sw_out),   32'hE);
      applyStimulus(1'b1, 4'hE, 1);
      checkOutput("simul_changed_drop", 32'(changed), 32'h0);

      // Release ch1, then reset in the middle of a new ch1 count
      applyStimulus(1'b1, 4'hC, 8);
      checkOutput("pre_mid_sw_out", 32'(sw_out), 32'hC);
      applyStimulus(1'b1, 4'hE, 3);
      applyStimulus(1'b0, 4'hE, 1);
      checkOutput("mid_rst_sw_out", 32'(sw_out), 32'h0);
      applyStimulus(1'b1, 4'hE, 2);
      checkOutput("mid_old_terminal", 32'(rise[1]), 32'h0);
      applyStimulus(1'b1, 4'hE, 3);
      checkOutput("mid_before", 32'(sw_out[1]), 32'h0);
      applyStimulus(1'b1, 4'hE, 1);
      checkOutput("mid_rise1",  32'(rise[1]), 32'h1);
      checkOutput("mid_rise",   32'(rise),    32'hE);
      applyStimulus(1'b1, 4'hE, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
